// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the RV32I 5-stage pipe: load-use stalls, data-memory
// freeze with timeout detection, branch flush, EX operand forwarding and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             DM_valid,
  input  logic             branch_taken,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             ex_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);
  localparam logic [1:0]  FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic [1:0]  flush_cnt, flush_nxt;
  logic        freeze, run_eval;
  logic        c_stall, c_ex_stall, c_bubble, c_flush;
  logic        load_use, mem_busy;

  assign load_use = ex_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_busy = mem_req && !DM_valid;

  // NOTE: every variable gets a default at the top of the block so no path leaves
  // one unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    flush_nxt  = flush_cnt;
    freeze     = 1'b0;
    run_eval   = 1'b0;
    c_stall    = 1'b0;
    c_ex_stall = 1'b0;
    c_bubble   = 1'b0;
    c_flush    = 1'b0;

    case (state)
      RUN:      if (mem_busy) freeze = 1'b1; else run_eval = 1'b1;
      MEM_WAIT: if (!DM_valid) freeze = 1'b1; else run_eval = 1'b1;
      FLUSH: begin
        if (mem_busy) begin
          freeze = 1'b1;
        end else begin
          c_flush  = 1'b1;
          c_bubble = 1'b1;
          if (flush_cnt <= 2'd1) begin
            state_nxt = RUN;
            flush_nxt = 2'd0;
          end else begin
            flush_nxt = flush_cnt - 2'd1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase

    if (freeze) begin
      c_stall    = 1'b1;
      c_ex_stall = 1'b1;
      state_nxt  = MEM_WAIT;
      if (state == MEM_WAIT)
        wait_nxt = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
      else
        wait_nxt = 16'd1;
    end

    // Branch beats load-use: the dependent instruction is younger and gets flushed anyway.
    if (run_eval) begin
      state_nxt = RUN;
      if (branch_taken) begin
        c_flush  = 1'b1;
        c_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
          flush_nxt = FLUSH_INIT;
        end
      end else if (load_use) begin
        c_stall  = 1'b1;
        c_bubble = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      wait_cnt        <= '0;
      flush_cnt       <= '0;
      mem_timeout_err <= 1'b0;
      stall_cycles    <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      flush_cnt <= flush_nxt;
      if (freeze && (wait_nxt >= TIMEOUT))
        mem_timeout_err <= 1'b1;
      if (perf_clr)
        stall_cycles <= '0;
      else if (c_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) return 2'b01;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs))    return 2'b10;
    return 2'b00;
  endfunction

  // Combinational outputs are forced low while reset is held.
  assign pc_stall     = rst && c_stall;
  assign if_id_stall  = rst && c_stall;
  assign ex_stall     = rst && c_ex_stall;
  assign id_ex_bubble = rst && c_bubble;
  assign if_id_flush  = rst && c_flush;
  assign fwd_a        = rst ? fwd_sel(ex_rs1) : 2'b00;
  assign fwd_b        = rst ? fwd_sel(ex_rs2) : 2'b00;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares every cycle.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, ex_rs1 = '0, ex_rs2 = '0, mem_rd = '0, wb_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_load = 0, mem_reg_write = 0, wb_reg_write = 0;
  logic mem_req = 0, DM_valid = 0, branch_taken = 0, perf_clr = 0;
  logic pc_stall, if_id_stall, ex_stall, id_ex_bubble, if_id_flush, mem_timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .DM_valid(DM_valid), .branch_taken(branch_taken), .perf_clr(perf_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .ex_stall(ex_stall),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  // Bit layout: pc_stall if_id_stall ex_stall bubble flush fwd_a fwd_b err stall_cycles
  typedef struct packed {
    logic       pc_stall;
    logic       if_id_stall;
    logic       ex_stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       err;
    logic [3:0] sc;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic obs_t ex(input logic ps, input logic exs, input logic bub, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic err, input logic [3:0] sc);
    obs_t o;
    o.pc_stall    = ps;
    o.if_id_stall = ps;
    o.ex_stall    = exs;
    o.bubble      = bub;
    o.flush       = fl;
    o.fwd_a       = fa;
    o.fwd_b       = fb;
    o.err         = err;
    o.sc          = sc;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pc_stall, if_id_stall, ex_stall, id_ex_bubble, if_id_flush,
           fwd_a, fwd_b, mem_timeout_err, stall_cycles};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (ps ifs exs bub fl fa fb err sc)", n, a, e);
      end
    end
  end

  task automatic idle();
    rst = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_load = 0; ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    mem_reg_write = 0; wb_reg_write = 0; mem_req = 0; DM_valid = 0;
    branch_taken = 0; perf_clr = 0;
  endtask

  task automatic lu5();
    ex_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  // Inputs are set just after posedge; the monitor checks at the following negedge.
  task automatic chk(input string name, input obs_t e);
    name_q.push_back(name);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: outputs low whatever the inputs
    rst = 0; mem_req = 1; ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1; lu5();
    chk("reset_hold", ex(0,0,0,0,2'b00,2'b00,0,0));

    // Load-use
    idle(); lu5();                       chk("load_use_rs1",     ex(1,0,1,0,2'b00,2'b00,0,0));
    idle();                              chk("load_use_release", ex(0,0,0,0,2'b00,2'b00,0,1));
    idle(); ex_load = 1; id_use_rs1 = 1; chk("load_use_x0",      ex(0,0,0,0,2'b00,2'b00,0,1));
    idle(); ex_load = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
                                         chk("load_use_rs2",     ex(1,0,1,0,2'b00,2'b00,0,1));
    idle(); ex_load = 1; ex_rd = 9; id_rs2 = 9; perf_clr = 1;
                                         chk("rs2_unused",       ex(0,0,0,0,2'b00,2'b00,0,2));

    // Memory freeze: 4 busy cycles, error rises after the 3rd
    idle(); mem_req = 1;                 chk("mem_freeze_1",     ex(1,1,0,0,2'b00,2'b00,0,0));
                                         chk("mem_freeze_2",     ex(1,1,0,0,2'b00,2'b00,0,1));
                                         chk("mem_freeze_3",     ex(1,1,0,0,2'b00,2'b00,0,2));
                                         chk("mem_freeze_4",     ex(1,1,0,0,2'b00,2'b00,1,3));
    DM_valid = 1;                        chk("mem_release",      ex(0,0,0,0,2'b00,2'b00,1,4));
    idle();                              chk("mem_stall_count",  ex(0,0,0,0,2'b00,2'b00,1,4));

    // Forwarding
    idle(); mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_reg_write = 1; wb_reg_write = 1;
                                         chk("fwd_a_mem",        ex(0,0,0,0,2'b01,2'b00,1,4));
    mem_reg_write = 0;                   chk("fwd_a_wb",         ex(0,0,0,0,2'b10,2'b00,1,4));
    idle(); mem_reg_write = 1; wb_reg_write = 1;
                                         chk("fwd_x0",           ex(0,0,0,0,2'b00,2'b00,1,4));
    idle(); ex_rs1 = 4; ex_rs2 = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
                                         chk("fwd_b_mem",        ex(0,0,0,0,2'b00,2'b01,1,4));
    mem_reg_write = 0;                   chk("fwd_b_wb",         ex(0,0,0,0,2'b00,2'b10,1,4));

    // Reset clears sticky error and counter
    idle(); rst = 0;                     chk("reset_clear",      ex(0,0,0,0,2'b00,2'b00,0,0));

    // Timeout, branch held during freeze, released into FLUSH
    idle(); mem_req = 1;                 chk("to_freeze_1",      ex(1,1,0,0,2'b00,2'b00,0,0));
                                         chk("to_freeze_2",      ex(1,1,0,0,2'b00,2'b00,0,1));
                                         chk("timeout_pre",      ex(1,1,0,0,2'b00,2'b00,0,2));
                                         chk("timeout_rise",     ex(1,1,0,0,2'b00,2'b00,1,3));
    branch_taken = 1;                    chk("branch_held",      ex(1,1,0,0,2'b00,2'b00,1,4));
    DM_valid = 1;                        chk("release_branch",   ex(0,0,1,1,2'b00,2'b00,1,5));
    idle();                              chk("flush_2nd",        ex(0,0,1,1,2'b00,2'b00,1,5));
    idle();                              chk("flush_done",       ex(0,0,0,0,2'b00,2'b00,1,5));

    // Branch with simultaneous load-use
    idle(); lu5(); branch_taken = 1;     chk("branch_over_lu",   ex(0,0,1,1,2'b00,2'b00,1,5));
    branch_taken = 0;                    chk("flush_ignores_lu", ex(0,0,1,1,2'b00,2'b00,1,5));
    idle();                              chk("flush_end",        ex(0,0,0,0,2'b00,2'b00,1,5));

    // Memory busy interrupts FLUSH
    idle(); branch_taken = 1;            chk("branch_2",         ex(0,0,1,1,2'b00,2'b00,1,5));
    idle(); mem_req = 1;                 chk("flush_to_mem",     ex(1,1,0,0,2'b00,2'b00,1,5));
    idle(); DM_valid = 1;                chk("mem_after_flush",  ex(0,0,0,0,2'b00,2'b00,1,6));
    idle();                              chk("flush_discarded",  ex(0,0,0,0,2'b00,2'b00,1,6));

    // Reset mid MEM_WAIT
    idle(); mem_req = 1;                 chk("mw_freeze_1",      ex(1,1,0,0,2'b00,2'b00,1,6));
                                         chk("mw_freeze_2",      ex(1,1,0,0,2'b00,2'b00,1,7));
    rst = 0;                             chk("reset_mid_wait",   ex(0,0,0,0,2'b00,2'b00,0,0));
    idle();                              chk("reset_to_run",     ex(0,0,0,0,2'b00,2'b00,0,0));

    // perf_clr beats increment
    idle(); lu5(); perf_clr = 1;         chk("clr_with_stall",   ex(1,0,1,0,2'b00,2'b00,0,0));
    idle();                              chk("clr_wins",         ex(0,0,0,0,2'b00,2'b00,0,0));

    // Counter saturation at all-ones
    idle(); mem_req = 1;
    for (int i = 0; i < 16; i++)
      chk("sat_freeze", ex(1,1,0,0,2'b00,2'b00,(i >= 3),4'(i)));
    DM_valid = 1;                        chk("stall_sat",        ex(0,0,0,0,2'b00,2'b00,1,15));
    idle();

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
